// File: rtl/queue_2bit_writer.sv
// Producer side of the 2-bit symbol queue: collects symbols into a local buffer,
// hands the whole buffer to the queue with a one-cycle ld strobe, then waits for it to drain.
// IDX_W must satisfy 2**IDX_W > DEPTH so that a full count is representable.
module queue_2bit_writer #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           in_data,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 drain_done,
    output logic                 ld,
    output logic [2*DEPTH-1:0]   ld_data,
    output logic [IDX_W-1:0]     rear_index,
    output logic                 full,
    output logic                 busy
);

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_HANDOFF = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;

    localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic               guard_q, guard_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [2*DEPTH-1:0] buf_q, buf_d;

    logic               accept;
    logic [IDX_W-1:0]   post_count;

    // Every handshake-facing output decodes registered state only, never in_valid or flush.
    assign in_ready   = (state_q == ST_FILL) && (count_q < DEPTH_C);
    assign ld         = (state_q == ST_HANDOFF);
    assign busy       = (state_q != ST_FILL);
    assign full       = (count_q == DEPTH_C);
    assign rear_index = count_q;
    assign ld_data    = buf_q;

    assign accept     = in_valid && in_ready;
    assign post_count = count_q + IDX_W'(accept);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        guard_d = guard_q;
        count_d = count_q;
        buf_d   = buf_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_q == IDX_W'(i)) begin
                            buf_d[2*i +: 2] = in_data;
                        end
                    end
                    count_d = post_count;
                end
                // A flush in the same cycle as an accept carries that symbol along.
                if ((accept && (post_count == DEPTH_C)) ||
                    (flush && (post_count != '0))) begin
                    state_d = ST_HANDOFF;
                end
            end

            ST_HANDOFF: begin
                state_d = ST_WAIT;
                guard_d = 1'b1;
            end

            ST_WAIT: begin
                // The queue only latches the new rear index during the first wait cycle,
                // so its finish flag is stale until then.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (drain_done) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    buf_d   = '0;
                end
            end

            default: begin
                state_d = ST_FILL;
                guard_d = 1'b0;
                count_d = '0;
                buf_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FILL;
            guard_q <= 1'b0;
            count_q <= '0;
            // NOTE: the buffer is reset too, because unwritten entries must read as zero.
            buf_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so all state advances together at the edge.
            state_q <= state_d;
            guard_q <= guard_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_queue_2bit_writer.sv
// Self-checking bench for queue_2bit_writer: a queue-of-symbols reference model with a
// handoff timer, a scoreboard of expected handoffs, and an independent ld monitor.
module tb_queue_2bit_writer;

    localparam int DEPTH = 256;
    localparam int IDX_W = 9;
    localparam int DW    = 2 * DEPTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_data = 2'b00;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             drain_done = 1'b0;
    logic             ld;
    logic [DW-1:0]    ld_data;
    logic [IDX_W-1:0] rear_index;
    logic             full;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: symbols held, and cycles since the handoff trigger (-1 while collecting).
    int m_syms[$];
    int m_age = -1;

    // Scoreboard of handoffs the model expects the DUT to present on ld.
    logic [DW-1:0] sb_data[$];
    int            sb_count[$];

    always #5 clk = ~clk;

    queue_2bit_writer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .drain_done (drain_done),
        .ld         (ld),
        .ld_data    (ld_data),
        .rear_index (rear_index),
        .full       (full),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack_syms();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < m_syms.size(); i++) begin
            v[2*i +: 2] = 2'(m_syms[i]);
        end
        return v;
    endfunction

    task automatic check_outputs();
        check("in_ready",   DW'(in_ready),   DW'(m_age < 0 && m_syms.size() < DEPTH));
        check("ld",         DW'(ld),         DW'(m_age == 1));
        check("busy",       DW'(busy),       DW'(m_age > 0));
        check("full",       DW'(full),       DW'(m_syms.size() == DEPTH));
        check("rear_index", DW'(rear_index), DW'(m_syms.size()));
        if (m_age < 0 && m_syms.size() == 0) begin
            check("ld_data_clear", ld_data, '0);
        end
    endtask

    // Applies the rules to one clock edge given the inputs presented for that edge.
    task automatic model_edge(input bit v, input bit [1:0] d, input bit f, input bit dr, input bit r);
        bit acc;
        if (!r) begin
            m_syms.delete();
            m_age = -1;
        end else if (m_age < 0) begin
            acc = v && (m_syms.size() < DEPTH);
            if (acc) m_syms.push_back(int'(d));
            if ((acc && m_syms.size() == DEPTH) || (f && m_syms.size() > 0)) begin
                sb_data.push_back(pack_syms());
                sb_count.push_back(m_syms.size());
                m_age = 1;
            end
        end else if (m_age < 3) begin
            m_age++;
        end else if (dr) begin
            m_syms.delete();
            m_age = -1;
        end
    endtask

    task automatic step(input bit v, input bit [1:0] d, input bit f, input bit dr, input bit r);
        @(negedge clk);
        check_outputs();
        in_valid   = v;
        in_data    = d;
        flush      = f;
        drain_done = dr;
        rst        = r;
        model_edge(v, d, f, dr, r);
    endtask

    // Monitor: every ld pulse must match the oldest expected handoff.
    always @(negedge clk) begin
        if (ld === 1'b1) begin
            if (sb_count.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ld: got ld=1 expected no handoff (t=%0t)", $time);
            end else begin
                check("handoff_count", DW'(rear_index), DW'(sb_count.pop_front()));
                check("handoff_data", ld_data, sb_data.pop_front());
            end
        end
    end

    initial begin
        // Reset held for two cycles.
        step(0, 2'd0, 0, 0, 0);
        step(0, 2'd0, 0, 0, 0);
        step(0, 2'd0, 0, 0, 1);

        // Partial flush of 1,2,3 with flush alongside the third symbol.
        step(1, 2'd1, 0, 0, 1);
        step(1, 2'd2, 0, 0, 1);
        step(1, 2'd3, 1, 0, 1);
        repeat (4) step(0, 2'd0, 0, 0, 1);
        step(0, 2'd0, 0, 1, 1);
        step(0, 2'd0, 0, 0, 1);

        // Flush with an empty buffer is ignored.
        repeat (2) step(0, 2'd0, 1, 0, 1);

        // Full buffer with drain_done held high across the handoff.
        for (int i = 0; i < DEPTH; i++) step(1, 2'(i % 4), 0, 1, 1);
        repeat (3) step(0, 2'd0, 1, 1, 1);
        step(0, 2'd0, 1, 0, 1);

        // Flush during a long wait is ignored.
        for (int i = 0; i < 5; i++) step(1, 2'(i), (i == 4), 0, 1);
        repeat (6) step(0, 2'd0, 1, 0, 1);
        step(0, 2'd0, 0, 1, 1);

        // Reset in the handoff cycle.
        step(1, 2'd1, 0, 0, 1);
        step(1, 2'd2, 1, 0, 1);
        step(0, 2'd0, 0, 0, 0);
        repeat (2) step(0, 2'd0, 0, 0, 1);
        step(1, 2'd3, 0, 0, 1);
        step(1, 2'd2, 1, 0, 1);
        repeat (3) step(0, 2'd0, 0, 0, 1);

        // Reset during the wait, then a fresh two-symbol handoff.
        step(0, 2'd0, 0, 0, 0);
        step(0, 2'd0, 0, 0, 1);
        step(1, 2'd0, 0, 0, 1);
        step(1, 2'd1, 1, 0, 1);
        repeat (3) step(0, 2'd0, 0, 0, 1);
        step(0, 2'd0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 4) != 0, 2'($urandom), ($urandom % 16) == 0,
                 ($urandom % 3) == 0, ($urandom % 200) != 0);
        end

        repeat (3) step(0, 2'd0, 0, 0, 1);
        check("scoreboard_drained", DW'(sb_count.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
